// File: rtl/wordcount_pkg.sv
// Shared constants, count type and controller state encoding for the word-count accumulator.
package wordcount_pkg;

  localparam int unsigned ACCUM_DEPTH_DEFAULT = 1024;
  localparam int unsigned COUNT_W             = 64;
  localparam int unsigned ADDR_W              = 32;

  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DRAIN,
    ST_CLEAR,
    ST_DUMP_RD,
    ST_DUMP_WAIT,
    ST_DUMP_OUT
  } state_e;

  typedef enum logic {
    OP_CLEAR,
    OP_DUMP
  } op_e;

endpackage

// File: rtl/wordcount_accum_if.sv
// Increment-request, control and AXI-stream dump signals of the accumulator.
interface wordcount_accum_if;
  import wordcount_pkg::*;

  logic [ADDR_W-1:0] accum_addr;
  count_t            accum_din;
  logic              accum_we;
  logic              clear_kick;
  logic              dump_kick;
  logic              busy;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  count_t            m_axis_tdata;
  logic              m_axis_tlast;
  logic              drop_busy;
  logic              drop_range;

  modport slave (
    input  accum_addr, accum_din, accum_we, clear_kick, dump_kick, m_axis_tready,
    output busy, m_axis_tvalid, m_axis_tdata, m_axis_tlast, drop_busy, drop_range
  );

  modport master (
    output accum_addr, accum_din, accum_we, clear_kick, dump_kick, m_axis_tready,
    input  busy, m_axis_tvalid, m_axis_tdata, m_axis_tlast, drop_busy, drop_range
  );

endinterface

// File: rtl/wordcount_accum_ram.sv
// Simple dual-port count memory: one write port, one registered read port, read-first, no reset.
module wordcount_accum_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wordcount_accum.sv
// Saturating per-entry counter bank: two-stage read-modify-write with forwarding, plus a
// controller that clears the bank or streams every entry out over AXI-stream.
module wordcount_accum
  import wordcount_pkg::*;
#(
  parameter int unsigned ACCUM_DEPTH = ACCUM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  wordcount_accum_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ACCUM_DEPTH);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t              LAST_IDX = idx_t'(ACCUM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(ACCUM_DEPTH);

  state_e state_q;
  op_e    op_q;
  idx_t   idx_q;
  logic   busy_q;
  logic   tvalid_q;
  logic   tlast_q;
  count_t tdata_q;
  logic   drop_busy_q;
  logic   drop_range_q;

  logic   s1_valid_q;
  idx_t   s1_addr_q;
  count_t s1_din_q;
  logic   fw_valid_q;
  idx_t   fw_addr_q;
  count_t fw_sum_q;

  logic   in_range;
  logic   req_ok;
  count_t old_val;
  count_t sum_d;
  logic [COUNT_W:0] sum_wide;

  logic   ram_we;
  idx_t   ram_waddr;
  count_t ram_wdata;
  idx_t   ram_raddr;
  count_t ram_rdata;

  assign in_range = bus.accum_addr < DEPTH_A;
  assign req_ok   = bus.accum_we && !busy_q && in_range;

  // The RAM still holds the pre-write value when the previous request hit the same entry.
  always_comb begin
    old_val  = (fw_valid_q && (fw_addr_q == s1_addr_q)) ? fw_sum_q : ram_rdata;
    sum_wide = {1'b0, old_val} + {1'b0, s1_din_q};
    sum_d    = sum_wide[COUNT_W] ? '1 : sum_wide[COUNT_W-1:0];
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr_q;
    ram_wdata = sum_d;
    if (state_q == ST_CLEAR) begin
      ram_we    = !reset;
      ram_waddr = idx_q;
      ram_wdata = '0;
    end else if (s1_valid_q && !reset) begin
      ram_we = 1'b1;
    end
    ram_raddr = (state_q == ST_DUMP_RD) ? idx_q : bus.accum_addr[IDX_W-1:0];
  end

  wordcount_accum_ram #(
    .DEPTH (ACCUM_DEPTH),
    .WIDTH (COUNT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_CLEAR;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      drop_busy_q  <= 1'b0;
      drop_range_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_din_q     <= '0;
      fw_valid_q   <= 1'b0;
      fw_addr_q    <= '0;
      fw_sum_q     <= '0;
    end else begin
      s1_valid_q <= req_ok;
      s1_addr_q  <= bus.accum_addr[IDX_W-1:0];
      s1_din_q   <= bus.accum_din;
      fw_valid_q <= s1_valid_q;
      fw_addr_q  <= s1_addr_q;
      fw_sum_q   <= sum_d;

      // A drop arriving in the same cycle as an accepted clear still registers.
      if (state_q == ST_IDLE && bus.clear_kick) begin
        drop_busy_q  <= 1'b0;
        drop_range_q <= 1'b0;
      end
      if (bus.accum_we && busy_q) drop_busy_q <= 1'b1;
      if (bus.accum_we && !in_range) drop_range_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.clear_kick) begin
            op_q    <= OP_CLEAR;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_DRAIN;
          end else if (bus.dump_kick) begin
            op_q    <= OP_DUMP;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_DRAIN;
          end
        end
        ST_WAIT_DRAIN: begin
          if (!s1_valid_q) begin
            idx_q   <= '0;
            state_q <= (op_q == OP_CLEAR) ? ST_CLEAR : ST_DUMP_RD;
          end
        end
        ST_CLEAR: begin
          idx_q <= idx_q + idx_t'(1);
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DUMP_RD: begin
          state_q <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          tdata_q  <= ram_rdata;
          tvalid_q <= 1'b1;
          tlast_q  <= (idx_q == LAST_IDX);
          state_q  <= ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (bus.m_axis_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + idx_t'(1);
              state_q <= ST_DUMP_RD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.drop_busy     = drop_busy_q;
  assign bus.drop_range    = drop_range_q;

endmodule

// File: tb/tb_wordcount_accum.sv
// Randomised self-checking bench for wordcount_accum against an array-of-counts reference model.
module tb_wordcount_accum;
  import wordcount_pkg::*;

  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wordcount_accum_if bus ();

  wordcount_accum #(.ACCUM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] model [DEPTH];
  logic        exp_drop_busy;
  logic        exp_drop_range;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    if (b > ~a) return '1;
    return a + b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int unsigned addr, input logic [63:0] din);
    bus.accum_we   = 1'b1;
    bus.accum_addr = 32'(addr);
    bus.accum_din  = din;
    if (addr < DEPTH) model[addr] = sat_add(model[addr], din);
    else exp_drop_range = 1'b1;
    step();
    bus.accum_we = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_drop_busy"},  64'(bus.drop_busy),  64'(exp_drop_busy));
    check_eq({tag, "_drop_range"}, 64'(bus.drop_range), 64'(exp_drop_range));
  endtask

  task automatic do_clear(input bit with_dump);
    int n;
    bit seen_valid;
    bus.clear_kick = 1'b1;
    bus.dump_kick  = with_dump;
    step();
    bus.clear_kick = 1'b0;
    bus.dump_kick  = 1'b0;
    check_eq("clear_busy_rise", 64'(bus.busy), 64'd1);
    n = 0;
    seen_valid = 1'b0;
    while (bus.busy && n < 3000) begin
      if (bus.m_axis_tvalid) seen_valid = 1'b1;
      n++;
      step();
    end
    check_eq("clear_busy_cycles", 64'(n), 64'd1025);
    check_eq("clear_no_tvalid", 64'(seen_valid), 64'd0);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    exp_drop_busy  = 1'b0;
    exp_drop_range = 1'b0;
    check_flags("after_clear");
    if (with_dump) begin
      step();
      step();
      check_eq("ignored_dump_busy", 64'(bus.busy), 64'd0);
      check_eq("ignored_dump_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    end
  endtask

  // abort_at > 0 stops after that many accepted beats; inj_cyc >= 0 injects a request mid-dump.
  task automatic do_dump(input bit toggle, input int abort_at, input int inj_cyc, output int beats);
    int cyc;
    bit prev_stall;
    logic [63:0] prev_data;
    bus.dump_kick = 1'b1;
    step();
    bus.dump_kick = 1'b0;
    check_eq("dump_busy_rise", 64'(bus.busy), 64'd1);
    beats = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (beats < int'(DEPTH) && cyc < 8000 && !(abort_at > 0 && beats == abort_at)) begin
      bus.m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == inj_cyc) begin
        bus.accum_we   = 1'b1;
        bus.accum_addr = 32'd5;
        bus.accum_din  = 64'd100;
        exp_drop_busy  = 1'b1;
      end else begin
        bus.accum_we = 1'b0;
      end
      if (prev_stall) begin
        check_eq("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        check_eq("stall_tdata", bus.m_axis_tdata, prev_data);
      end
      if (bus.m_axis_tvalid) begin
        if (bus.m_axis_tready) begin
          check_eq($sformatf("beat%0d_data", beats), bus.m_axis_tdata, model[beats]);
          check_eq($sformatf("beat%0d_tlast", beats), 64'(bus.m_axis_tlast),
                   64'(beats == int'(DEPTH) - 1));
          beats++;
        end
        prev_stall = !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
      end else begin
        check_eq("tlast_without_tvalid", 64'(bus.m_axis_tlast), 64'd0);
        prev_stall = 1'b0;
      end
      step();
      cyc++;
    end
    bus.accum_we = 1'b0;
    if (abort_at > 0) begin
      check_eq("abort_beats", 64'(beats), 64'(abort_at));
    end else begin
      check_eq("dump_beats", 64'(beats), 64'(DEPTH));
      check_eq("dump_busy_fall", 64'(bus.busy), 64'd0);
      check_eq("dump_tvalid_fall", 64'(bus.m_axis_tvalid), 64'd0);
    end
    bus.m_axis_tready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int unsigned addr;
    int unsigned r;
    logic [63:0] din;

    bus.accum_we      = 1'b0;
    bus.accum_addr    = '0;
    bus.accum_din     = '0;
    bus.clear_kick    = 1'b0;
    bus.dump_kick     = 1'b0;
    bus.m_axis_tready = 1'b0;
    exp_drop_busy     = 1'b0;
    exp_drop_range    = 1'b0;
    reset             = 1'b1;
    step();
    step();
    check_eq("reset_busy",   64'(bus.busy),          64'd0);
    check_eq("reset_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check_eq("reset_tlast",  64'(bus.m_axis_tlast),  64'd0);
    check_flags("reset");
    reset = 1'b0;
    step();

    do_clear(1'b0);
    do_dump(1'b0, 0, -1, beats);

    for (int i = 1; i <= 4; i++) send_req(5, 64'(i));
    do_dump(1'b1, 0, -1, beats);

    send_req(7, 64'hFFFF_FFFF_FFFF_FFF0);
    step();
    send_req(7, 64'h20);
    send_req(8, 64'hFFFF_FFFF_FFFF_FFFE);
    send_req(8, 64'd5);
    send_req(8, 64'd1);
    send_req(DEPTH, 64'd9);
    check_flags("range_drop");

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 99);
        if (r < 70)      addr = $urandom_range(0, 7);
        else if (r < 96) addr = $urandom_range(DEPTH - 8, DEPTH - 1);
        else             addr = $urandom_range(DEPTH, DEPTH + 40);
        r = $urandom_range(0, 99);
        if (r < 4) din = {$urandom, $urandom};
        else       din = 64'($urandom_range(0, 1000));
        send_req(addr, din);
      end else begin
        step();
      end
    end
    check_flags("random");

    do_dump(1'b1, 0, 20, beats);
    check_flags("busy_drop");

    do_dump(1'b0, 100, -1, beats);
    reset = 1'b1;
    step();
    check_eq("abort_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check_eq("abort_busy",   64'(bus.busy),          64'd0);
    check_eq("abort_tlast",  64'(bus.m_axis_tlast),  64'd0);
    exp_drop_busy  = 1'b0;
    exp_drop_range = 1'b0;
    check_flags("abort");
    reset = 1'b0;
    step();
    do_dump(1'b0, 0, -1, beats);

    do_clear(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wordcount_accum.md
WORDCOUNT_ACCUM -- requirements
Module: wordcount_accum

Interface
REQ-001 Parameter ACCUM_DEPTH, default 1024, number of 64-bit count entries (power of two).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 accum_addr  input  32  entry index of an increment request.
REQ-005 accum_din  input  64  increment value added to the entry.
REQ-006 accum_we  input  1  increment request strobe, one request per cycle, no back-pressure.
REQ-007 clear_kick  input  1  one-cycle pulse; zero all entries.
REQ-008 dump_kick  input  1  one-cycle pulse; stream all entries out.
REQ-009 busy  output  1  high from kick acceptance until clear/dump completes.
REQ-010 m_axis_tvalid  output  1  dump data valid.
REQ-011 m_axis_tready  input  1  downstream ready.
REQ-012 m_axis_tdata  output  64  entry count.
REQ-013 m_axis_tlast  output  1  high with entry ACCUM_DEPTH-1.
REQ-014 drop_busy  output  1  sticky: accum_we arrived while busy.
REQ-015 drop_range  output  1  sticky: accum_we with accum_addr >= ACCUM_DEPTH.

Function
REQ-016 The block SHALL run a two-stage read-modify-write: cycle N RAM read of accum_addr, cycle N+1 sum=old+accum_din, entry written at clk edge ending N+1.
REQ-017 Sum SHALL saturate at 64'hFFFF_FFFF_FFFF_FFFF, never wrap.
REQ-018 When requests at N and N+1 target the same entry, request N+1 SHALL use stage-1 sum (forwarding) instead of the RAM output; one increment per request, none lost.
REQ-019 Requests with accum_addr >= ACCUM_DEPTH SHALL be dropped (no write) and set drop_range.
REQ-020 accum_we while busy=1 SHALL be dropped and set drop_busy; requests already in the pipeline SHALL complete.
REQ-021 FSM states: IDLE, WAIT_DRAIN, CLEAR, DUMP_RD, DUMP_WAIT, DUMP_OUT.
REQ-022 IDLE: clear_kick -> WAIT_DRAIN(op=clear); else dump_kick -> WAIT_DRAIN(op=dump); simultaneous kicks: clear wins, dump ignored; busy rises the cycle after the kick.
REQ-023 WAIT_DRAIN: stays until the RMW pipeline is empty (max 2 cycles), then CLEAR or DUMP_RD with index=0.
REQ-024 CLEAR: writes zero to index, one entry per cycle; after ACCUM_DEPTH-1 -> IDLE, busy falls; total ACCUM_DEPTH cycles.
REQ-025 DUMP_RD issues RAM read of index; DUMP_WAIT captures data; DUMP_OUT holds tvalid=1, tdata stable until tready; on handshake index+1 -> DUMP_RD, or after last entry -> IDLE, busy falls.
REQ-026 m_axis_tlast SHALL be 1 only with tvalid for index ACCUM_DEPTH-1.
REQ-027 Kicks while busy=1 SHALL be ignored.
REQ-028 drop_busy/drop_range SHALL clear only on reset or on accepted clear_kick.
REQ-029 RAM contents are undefined after power-up; software SHALL clear before first use.

Reset
REQ-030 reset SHALL return FSM to IDLE and flush pipeline; busy, m_axis_tvalid, m_axis_tlast, drop_busy, drop_range = 0 the cycle after reset is sampled.
REQ-031 reset mid-clear or mid-dump SHALL abort the operation; RAM contents are not reset; in-flight RMW write SHALL be suppressed.

Structure
REQ-032 wordcount_pkg SHALL hold ACCUM_DEPTH default, count width (64), and the FSM state enum.
REQ-033 The count memory SHALL be a sub-module wordcount_accum_ram: simple dual-port, 1-cycle registered read, read-first, no reset.
REQ-034 Forwarding, saturation and FSM stay in wordcount_accum.

Verification
REQ-035 clear_kick, ACCUM_DEPTH=1024 -> busy high 1024+drain cycles; dump yields 1024 beats of 0, tlast on beat 1024 only.
REQ-036 accum_we to addr 5 on 4 consecutive cycles, din=1,2,3,4 -> dump entry 5 = 10, others 0.
REQ-037 addr 7 preloaded FFFF_FFFF_FFFF_FFF0, add 0x20 -> entry 7 = FFFF_FFFF_FFFF_FFFF.
REQ-038 dump with tready toggling 1/0 each cycle -> all beats in order, tdata stable while tvalid&!tready.
REQ-039 accum_we addr=1024 and accum_we during clear -> drop_range=1, drop_busy=1, no entries changed.
REQ-040 reset asserted mid-dump at beat 100 -> tvalid=0, busy=0 next cycle; new dump restarts at entry 0.
